uart_tx_fifo: RTL and testbench

Byte-buffering front end for the UART transmitter. It accepts bytes from the system side into a DEPTH-entry FIFO and hands them to `uart_tx` one frame at a time. For each byte it presents the byte on `tx_data`, pulses `flag_tx` and holds the byte stable until `uart_tx` returns `tx_done`. It sits directly upstream of `uart_tx`: `tx_data` drives `datain`, `flag_tx` drives `flag_tx`, and `tx_done` comes back from `tx_done`.

---
 rtl/uart_tx_fifo.sv | 116 +++++++++++
 tb/tb_uart_tx_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx. It buffers system-side writes and issues one
// flag_tx per byte, holding tx_data until the transmitter returns tx_done.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          wr_overflow,
  output logic [7:0]    tx_data,
  output logic          flag_tx,
  input  logic          tx_done,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          flag_tx_q, flag_tx_d;
  logic          wr_overflow_q, wr_overflow_d;
  logic          wr_accept;
  logic          pop;

  // Occupancy flags come from the registered count, so a pop in the same
  // cycle never frees room for a write that arrives while full.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en && !full;

  // Frame sequencing: IDLE launches a byte, SEND waits for tx_done, GAP lets
  // uart_tx drop tx_done and settle before the next start pulse.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d   = state_q;
    pop       = 1'b0;
    flag_tx_d = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          flag_tx_d = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tx_done) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_overflow_d = wr_en && full;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; emptiness is tracked by count, so stale entries are never read.
  always_ff @(posedge sysclk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tx_data_q     <= 8'h00;
      flag_tx_q     <= 1'b0;
      wr_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tx_data_q     <= tx_data_d;
      flag_tx_q     <= flag_tx_d;
      wr_overflow_q <= wr_overflow_d;
    end
  end

  assign count       = count_q;
  assign tx_data     = tx_data_q;
  assign flag_tx     = flag_tx_q;
  assign wr_overflow = wr_overflow_q;
  assign busy        = (state_q == SEND) || flag_tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a tx_done responder stands in for uart_tx, and a
// scoreboard queue checks every byte launched with flag_tx against the bytes written.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = 20;

  logic          sysclk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          wr_overflow;
  logic [7:0]    tx_data;
  logic          flag_tx;
  logic          tx_done;
  logic          busy;
  logic          model_done;
  logic          stray_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_idx   = 0;
  int done_cnt = 0;
  bit resp_en  = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];
  int         done_cyc[$];

  assign tx_done = model_done | stray_done;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .wr_overflow (wr_overflow),
    .tx_data     (tx_data),
    .flag_tx     (flag_tx),
    .tx_done     (tx_done),
    .busy        (busy)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Records every start pulse and every end-of-frame pulse with its cycle.
  always @(negedge sysclk) begin
    if (flag_tx === 1'b1) begin
      obs_data.push_back(tx_data);
      obs_cyc.push_back(cyc);
    end
    if (tx_done === 1'b1) done_cyc.push_back(cyc);
  end

  // Transmitter stand-in: tx_done arrives FRAME cycles after each flag_tx.
  initial begin
    model_done = 1'b0;
    forever begin
      @(posedge sysclk); #1;
      model_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) model_done = 1'b1;
      end
      if (resp_en && flag_tx === 1'b1) done_cnt = FRAME;
    end
  end

  task automatic step();
    @(posedge sysclk); #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < FRAME + 5 && done_cnt != 0; i++) step();
    step();
    rst = 1'b1; wr_en = 1'b0; stray_done = 1'b0; resp_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    rd_idx = obs_data.size();
  endtask

  task automatic sb_drain(input string name, input int budget);
    logic [7:0] e;
    int w = 0;
    while (exp_q.size() > 0) begin
      if (obs_data.size() > rd_idx) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs_data[rd_idx] !== e) begin
          n_fail++;
          $display("FAIL %s byte %0d: got %h expected %h", name, rd_idx, obs_data[rd_idx], e);
        end
        rd_idx++;
      end else if (w >= budget) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout: got %0d bytes outstanding expected 0", name, exp_q.size());
        exp_q.delete();
      end else begin
        @(negedge sysclk);
        w++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge sysclk);
    n_checks++; if (empty !== 1'b1)       begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0)        begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (count !== 5'd0)       begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (flag_tx !== 1'b0)     begin n_fail++; $display("FAIL reset_flag: got %b expected 0", flag_tx); end
    n_checks++; if (tx_data !== 8'h00)    begin n_fail++; $display("FAIL reset_txdata: got %h expected 00", tx_data); end
    n_checks++; if (wr_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", wr_overflow); end
  endtask

  task automatic test_single();
    int n;
    bit e_busy, e_flag;
    logic [7:0] e_data;
    logic [AW:0] e_cnt;
    do_reset();
    resp_en = 1'b1;
    step();
    n = cyc;
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    step();
    wr_en = 1'b0;
    repeat (24) begin
      @(negedge sysclk);
      e_flag = (cyc == n + 2);
      e_busy = (cyc >= n + 2) && (cyc <= n + 2 + FRAME);
      e_data = (cyc >= n + 2) ? 8'hA5 : 8'h00;
      e_cnt  = (cyc == n + 1) ? 5'd1 : 5'd0;
      n_checks++; if (flag_tx !== e_flag) begin n_fail++; $display("FAIL single_flag cyc+%0d: got %b expected %b", cyc - n, flag_tx, e_flag); end
      n_checks++; if (busy !== e_busy)    begin n_fail++; $display("FAIL single_busy cyc+%0d: got %b expected %b", cyc - n, busy, e_busy); end
      n_checks++; if (tx_data !== e_data) begin n_fail++; $display("FAIL single_txdata cyc+%0d: got %h expected %h", cyc - n, tx_data, e_data); end
      n_checks++; if (count !== e_cnt)    begin n_fail++; $display("FAIL single_count cyc+%0d: got %0d expected %0d", cyc - n, count, e_cnt); end
    end
    sb_drain("single", 5);
  endtask

  task automatic test_back_to_back();
    int base, dbase, peak, ovf, w;
    do_reset();
    resp_en = 1'b1;
    base = obs_data.size(); dbase = done_cyc.size(); peak = 0; ovf = 0; w = 0;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = i[7:0]; exp_q.push_back(i[7:0]);
      @(negedge sysclk);
      if (int'(count) > peak) peak = int'(count);
      if (wr_overflow === 1'b1) ovf++;
      step();
    end
    wr_en = 1'b0;
    while (done_cyc.size() - dbase < DEPTH && w < DEPTH * (FRAME + 3) + 40) begin
      @(negedge sysclk);
      if (int'(count) > peak) peak = int'(count);
      if (wr_overflow === 1'b1) ovf++;
      w++;
    end
    n_checks++; if (done_cyc.size() - dbase != DEPTH) begin n_fail++; $display("FAIL burst_frames: got %0d expected %0d", done_cyc.size() - dbase, DEPTH); end
    n_checks++; if (obs_data.size() - base != DEPTH)  begin n_fail++; $display("FAIL burst_pulses: got %0d expected %0d", obs_data.size() - base, DEPTH); end
    n_checks++; if (peak != DEPTH - 1) begin n_fail++; $display("FAIL burst_peak: got %0d expected %0d", peak, DEPTH - 1); end
    n_checks++; if (ovf != 0)          begin n_fail++; $display("FAIL burst_ovf: got %0d expected 0", ovf); end
    for (int i = 1; i < DEPTH; i++) begin
      if (obs_cyc.size() > base + i && done_cyc.size() > dbase + i - 1) begin
        n_checks++;
        if (obs_cyc[base + i] - done_cyc[dbase + i - 1] != 3) begin
          n_fail++;
          $display("FAIL burst_gap %0d: got %0d expected 3", i, obs_cyc[base + i] - done_cyc[dbase + i - 1]);
        end
      end
    end
    sb_drain("burst", 5);
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    step();
    n = cyc;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + i[7:0];
      if (i < DEPTH + 1) exp_q.push_back(8'h40 + i[7:0]);
      @(negedge sysclk);
      if (i == DEPTH) begin
        n_checks++; if (count !== 5'd15) begin n_fail++; $display("FAIL ovf_count16: got %0d expected 15", count); end
        n_checks++; if (full !== 1'b0)   begin n_fail++; $display("FAIL ovf_full16: got %b expected 0", full); end
      end
      if (i == DEPTH + 1) begin
        n_checks++; if (full !== 1'b1)        begin n_fail++; $display("FAIL ovf_full17: got %b expected 1", full); end
        n_checks++; if (wr_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", wr_overflow); end
      end
      step();
    end
    wr_en = 1'b0;
    @(negedge sysclk);
    n_checks++; if (wr_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b expected 1", wr_overflow); end
    n_checks++; if (count !== 5'd16)      begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", count); end
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL ovf_busy: got %b expected 1", busy); end
    step();
    @(negedge sysclk);
    n_checks++; if (wr_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b expected 0", wr_overflow); end
    n_checks++; if (obs_data.size() - rd_idx != 1) begin n_fail++; $display("FAIL ovf_inflight: got %0d pulses expected 1", obs_data.size() - rd_idx); end
  endtask

  // Continues from test_overflow: full, one byte in flight, tx_done never sent.
  task automatic test_pop_while_full();
    resp_en = 1'b1;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge sysclk);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL popfull_full: got %b expected 1", full); end
    step();
    wr_en = 1'b1; wr_data = 8'hCC; exp_q.push_back(8'hCC);
    @(negedge sysclk);
    n_checks++; if (wr_overflow !== 1'b1) begin n_fail++; $display("FAIL popfull_ovf: got %b expected 1", wr_overflow); end
    n_checks++; if (count !== 5'd15)      begin n_fail++; $display("FAIL popfull_count: got %0d expected 15", count); end
    n_checks++; if (flag_tx !== 1'b1)     begin n_fail++; $display("FAIL popfull_flag: got %b expected 1", flag_tx); end
    step();
    wr_en = 1'b0;
    @(negedge sysclk);
    n_checks++; if (count !== 5'd16)      begin n_fail++; $display("FAIL popfull_refill: got %0d expected 16", count); end
    n_checks++; if (wr_overflow !== 1'b0) begin n_fail++; $display("FAIL popfull_ovf_clear: got %b expected 0", wr_overflow); end
    sb_drain("popfull", (DEPTH + 2) * (FRAME + 3) + 40);
  endtask

  task automatic test_simultaneous();
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + i[7:0]; exp_q.push_back(8'h10 + i[7:0]);
      step();
    end
    wr_en = 1'b0;
    repeat (3) step();
    resp_en = 1'b1;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'h1F; exp_q.push_back(8'h1F);
    @(negedge sysclk);
    n_checks++; if (count !== 5'd3) begin n_fail++; $display("FAIL simul_pre: got %0d expected 3", count); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL simul_idle: got %b expected 0", busy); end
    step();
    wr_en = 1'b0;
    @(negedge sysclk);
    n_checks++; if (count !== 5'd3)    begin n_fail++; $display("FAIL simul_count: got %0d expected 3", count); end
    n_checks++; if (flag_tx !== 1'b1)  begin n_fail++; $display("FAIL simul_flag: got %b expected 1", flag_tx); end
    n_checks++; if (tx_data !== 8'h11) begin n_fail++; $display("FAIL simul_txdata: got %h expected 11", tx_data); end
    sb_drain("simul", 6 * (FRAME + 3) + 40);
  endtask

  task automatic test_reset_mid_frame();
    int sz;
    do_reset();
    step();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h60 + i[7:0];
      if (i == 0) exp_q.push_back(8'h60);
      step();
    end
    wr_en = 1'b0;
    sb_drain("mid_inflight", 10);
    step();
    @(negedge sysclk);
    n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL mid_queued: got %0d expected 5", count); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge sysclk);
    n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL mid_empty: got %b expected 1", empty); end
    n_checks++; if (count !== 5'd0)    begin n_fail++; $display("FAIL mid_count: got %0d expected 0", count); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_txdata: got %h expected 00", tx_data); end
    sz = obs_data.size();
    step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    repeat (10) step();
    @(negedge sysclk);
    n_checks++; if (obs_data.size() != sz) begin n_fail++; $display("FAIL mid_no_flag: got %0d pulses expected 0", obs_data.size() - sz); end
    n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL mid_stray_busy: got %b expected 0", busy); end
    rd_idx = obs_data.size();
    resp_en = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
    step();
    wr_en = 1'b0;
    sb_drain("mid_restart", 10);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; stray_done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_pop_while_full();
    test_simultaneous();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
